// File: rtl/ac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ac_ctrl_pkg
// Shared types and constants for the AC setpoint controller.
//   ac_ctrl_state_t : controller state; its numeric value is shown on the LCD
//   ac_dir_t        : step direction latched when a request starts
//   TEMP_MAX/MIN    : temperature code range (0 = 20 degrees, 7 = 27 degrees)
// ---------------------------------------------------------------------------
package ac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FAULT  = 3'd4
    } ac_ctrl_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } ac_dir_t;

    localparam int TEMP_MAX = 7;
    localparam int TEMP_MIN = 0;

endpackage

// File: rtl/ac_timeout_counter.sv
// ---------------------------------------------------------------------------
// ac_timeout_counter
// Tick-enabled, clearable, saturating counter used to time one step request.
// Ports:
//   clk_2, reset_n : clock, asynchronous active-low reset
//   tick           : step-rate enable
//   enable         : count only while a request is outstanding
//   clear          : synchronous clear, wins over counting
//   done           : count has reached LIMIT (and stays there)
// ---------------------------------------------------------------------------
module ac_timeout_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic done
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Count ticks while enabled; hold at LIMIT so done stays asserted.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && tick && !done) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/ac_setpoint_controller.sv
// ---------------------------------------------------------------------------
// ac_setpoint_controller
// Closed-loop sequencer that steps the AC temperature toward a stored
// setpoint one step at a time, pauses while dripping, and flags a fault when
// the AC stops answering step requests.
// Ports:
//   clk_2, reset_n      : clock, asynchronous active-low reset
//   tick                : step-rate enable (AC clock rate)
//   load, setpoint      : capture a new desired temperature
//   temperature         : current temperature reported by the AC
//   dripping            : AC drip flag
//   increase, decrease  : registered step requests to the AC
//   at_target           : idle and temperature equals the stored setpoint
//   busy                : a step is in progress (REQ or SETTLE)
//   fault               : AC did not respond in time
//   state_o             : state code for the LCD
// ---------------------------------------------------------------------------
module ac_setpoint_controller
    import ac_ctrl_pkg::*;
#(
    parameter int                    TEMP_NBITS    = 3,
    parameter logic [TEMP_NBITS-1:0] SP_RESET      = '0,
    parameter int                    TIMEOUT_TICKS = 4,
    parameter bit                    DRIP_ASSIST   = 1'b1
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  load,
    input  logic [TEMP_NBITS-1:0] setpoint,
    input  logic [TEMP_NBITS-1:0] temperature,
    input  logic                  dripping,
    output logic                  increase,
    output logic                  decrease,
    output logic                  at_target,
    output logic                  busy,
    output logic                  fault,
    output logic [2:0]            state_o
);

    localparam logic [TEMP_NBITS-1:0] T_MAX = TEMP_NBITS'(TEMP_MAX);
    localparam logic [TEMP_NBITS-1:0] T_MIN = TEMP_NBITS'(TEMP_MIN);

    ac_ctrl_state_t        state_q, state_d;
    ac_dir_t               dir_q, dir_d;
    logic [TEMP_NBITS-1:0] sp_q;
    logic [TEMP_NBITS-1:0] t0_q, t0_d;
    logic                  inc_q, inc_d;
    logic                  dec_q, dec_d;
    logic                  cnt_done;
    logic                  cnt_clear;
    logic                  stepped;
    logic [TEMP_NBITS-1:0] t0_up, t0_dn;

    assign t0_up = t0_q + 1'b1;
    assign t0_dn = t0_q - 1'b1;

    // A step counts only as exactly one code in the latched direction.
    assign stepped = (dir_q == DIR_UP) ? (temperature == t0_up)
                                       : (temperature == t0_dn);

    // The counter only runs while we stay in REQ; any exit clears it.
    assign cnt_clear = (state_d != ST_REQ);

    ac_timeout_counter #(
        .LIMIT (TIMEOUT_TICKS)
    ) u_timeout (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .tick    (tick),
        .enable  (state_q == ST_REQ),
        .clear   (cnt_clear),
        .done    (cnt_done)
    );

    // Next-state and next-request logic. load is checked first everywhere
    // so it beats a simultaneous step or timeout; in IDLE a load waits one
    // cycle so the decision is made against the new setpoint.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        t0_d    = t0_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!load) begin
                    if (dripping) begin
                        state_d = ST_HOLD;
                    end else if (temperature < sp_q) begin
                        state_d = ST_REQ;
                        dir_d   = DIR_UP;
                        t0_d    = temperature;
                        inc_d   = (temperature != T_MAX);
                    end else if (temperature > sp_q) begin
                        state_d = ST_REQ;
                        dir_d   = DIR_DOWN;
                        t0_d    = temperature;
                        dec_d   = (temperature != T_MIN);
                    end
                end
            end
            ST_REQ: begin
                if (load) begin
                    state_d = ST_IDLE;
                end else if (dripping) begin
                    state_d = ST_HOLD;
                end else if (stepped) begin
                    state_d = ST_SETTLE;
                end else if (cnt_done) begin
                    state_d = ST_FAULT;
                end else begin
                    inc_d = (dir_q == DIR_UP)   && (temperature != T_MAX);
                    dec_d = (dir_q == DIR_DOWN) && (temperature != T_MIN);
                end
            end
            ST_SETTLE: begin
                if (load || tick) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!dripping) begin
                    state_d = ST_IDLE;
                end else if (DRIP_ASSIST && (temperature < T_MAX)) begin
                    inc_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (load) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, setpoint and request registers; reset drops requests at once.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            sp_q    <= SP_RESET;
            t0_q    <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            t0_q    <= t0_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            if (load) begin
                sp_q <= setpoint;
            end
        end
    end

    assign increase  = inc_q;
    assign decrease  = dec_q;
    assign busy      = (state_q == ST_REQ) || (state_q == ST_SETTLE);
    assign fault     = (state_q == ST_FAULT);
    assign at_target = (state_q == ST_IDLE) && (temperature == sp_q);
    assign state_o   = state_q;

endmodule

// File: tb/tb_ac_setpoint_controller.sv
// ---------------------------------------------------------------------------
// tb_ac_setpoint_controller
// Self-checking bench: a directed vector table, closed-loop sequences with a
// simple AC plant, an asynchronous-reset sequence, and a randomized run
// checked against a cycle-level behavioural model of the controller rules.
// ---------------------------------------------------------------------------
module tb_ac_setpoint_controller;

    localparam int TIMEOUT  = 4;
    localparam int S_IDLE   = 0;
    localparam int S_REQ    = 1;
    localparam int S_SETTLE = 2;
    localparam int S_HOLD   = 3;
    localparam int S_FAULT  = 4;

    logic       clk_2 = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic       dripping = 1'b0;
    logic [2:0] setpoint = 3'd0;
    logic [2:0] temperature = 3'd0;
    logic       increase, decrease, at_target, busy, fault;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state, m_sp, m_cnt, m_t0;
    bit m_up, m_inc, m_dec;

    typedef struct {
        bit tk; bit ld; int sp; int temp; bit drip;
        int st; bit inc; bit dec; bit flt; bit at;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_2 = ~clk_2;

    ac_setpoint_controller #(
        .TEMP_NBITS    (3),
        .SP_RESET      (3'd0),
        .TIMEOUT_TICKS (TIMEOUT),
        .DRIP_ASSIST   (1'b1)
    ) dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .tick        (tick),
        .load        (load),
        .setpoint    (setpoint),
        .temperature (temperature),
        .dripping    (dripping),
        .increase    (increase),
        .decrease    (decrease),
        .at_target   (at_target),
        .busy        (busy),
        .fault       (fault),
        .state_o     (state_o)
    );

    function automatic void cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void modelReset();
        m_state = S_IDLE; m_sp = 0; m_cnt = 0; m_t0 = 0;
        m_up = 1'b0; m_inc = 1'b0; m_dec = 1'b0;
    endfunction

    // One clock edge of the controller rules, applied to the model.
    function automatic void modelStep(bit tk, bit ld, int spv, int tv, bit dr);
        int ns;
        bit ni, nd;
        ns = m_state; ni = 1'b0; nd = 1'b0;
        case (m_state)
            S_IDLE: begin
                if (!ld) begin
                    if (dr) ns = S_HOLD;
                    else if (tv != m_sp) begin
                        ns = S_REQ; m_up = (tv < m_sp); m_t0 = tv;
                        ni = m_up; nd = !m_up;
                    end
                end
            end
            S_REQ: begin
                if (ld) ns = S_IDLE;
                else if (dr) ns = S_HOLD;
                else if (tv == m_t0 + (m_up ? 1 : -1)) ns = S_SETTLE;
                else if (m_cnt >= TIMEOUT) ns = S_FAULT;
                else begin ni = m_up; nd = !m_up; end
            end
            S_SETTLE: if (ld || tk) ns = S_IDLE;
            S_HOLD: begin
                if (!dr) ns = S_IDLE;
                else ni = (tv < 7);
            end
            default: if (ld) ns = S_IDLE;
        endcase
        if (ns != S_REQ) m_cnt = 0;
        else if (m_state == S_REQ && tk && m_cnt < TIMEOUT) m_cnt++;
        if (ld) m_sp = spv;
        m_state = ns; m_inc = ni; m_dec = nd;
    endfunction

    task automatic applyStimulus(input bit tk, input bit ld, input int spv,
                                 input int tv, input bit dr);
        tick = tk; load = ld; setpoint = 3'(spv);
        temperature = 3'(tv); dripping = dr;
        modelStep(tk, ld, spv, tv, dr);
        @(posedge clk_2);
        #1;
    endtask

    task automatic checkOutput(input string name, input int st, input bit inc,
                               input bit dec, input bit flt, input bit at);
        cmp({name, " state_o"}, int'(state_o), st);
        cmp({name, " increase"}, int'(increase), int'(inc));
        cmp({name, " decrease"}, int'(decrease), int'(dec));
        cmp({name, " fault"}, int'(fault), int'(flt));
        cmp({name, " busy"}, int'(busy), int'(st == S_REQ || st == S_SETTLE));
        cmp({name, " at_target"}, int'(at_target), int'(at));
        cmp({name, " inc_and_dec"}, int'(increase && decrease), 0);
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_state, m_inc, m_dec, m_state == S_FAULT,
                    (m_state == S_IDLE) && (int'(temperature) == m_sp));
    endtask

    task automatic doReset(input int start_t);
        reset_n = 1'b0;
        tick = 1'b0; load = 1'b0; dripping = 1'b0; setpoint = 3'd0;
        temperature = 3'(start_t);
        modelReset();
        #13;
        @(negedge clk_2);
        reset_n = 1'b1;
    endtask

    // Closed loop with a plant that steps on tick while a request is high.
    task automatic runLoop(input string name, input int start_t, input int target,
                           input int exp_up, input int exp_dn);
        int  t, ups, dns;
        bit  pi, pd, done, ib, db, tk;
        doReset(start_t);
        t = start_t; ups = 0; dns = 0; pi = 0; pd = 0; done = 0;
        applyStimulus(1'b0, 1'b1, target, t, 1'b0);
        for (int c = 0; c < 400 && !done; c++) begin
            tk = (c % 4 == 3);
            ib = increase; db = decrease;
            applyStimulus(tk, 1'b0, 0, t, 1'b0);
            if (tk && ib && t < 7) t++;
            if (tk && db && t > 0) t--;
            if (increase && !pi) ups++;
            if (decrease && !pd) dns++;
            pi = increase; pd = decrease;
            if (state_o == 3'd0 && at_target && t == target) done = 1;
        end
        cmp({name, " reached_target"}, int'(done), 1);
        cmp({name, " increase_pulses"}, ups, exp_up);
        cmp({name, " decrease_pulses"}, dns, exp_dn);
        cmp({name, " final_state"}, int'(state_o), S_IDLE);
        cmp({name, " final_at_target"}, int'(at_target), 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        bit tk, ptk, ld, dr, ib, db;

        // Directed table: tk ld sp temp drip | state inc dec fault at_target
        vecs.push_back('{0,1,3,0,0, 0,0,0,0,0});
        vecs.push_back('{0,0,0,0,0, 1,1,0,0,0});
        vecs.push_back('{1,0,0,0,0, 1,1,0,0,0});
        vecs.push_back('{0,0,0,1,0, 2,0,0,0,0});
        vecs.push_back('{0,0,0,1,0, 2,0,0,0,0});
        vecs.push_back('{1,0,0,1,0, 0,0,0,0,0});
        vecs.push_back('{0,0,0,1,0, 1,1,0,0,0});
        vecs.push_back('{0,1,2,2,0, 0,0,0,0,1});
        vecs.push_back('{0,0,0,2,0, 0,0,0,0,1});
        vecs.push_back('{0,1,0,2,0, 0,0,0,0,0});
        vecs.push_back('{0,0,0,2,0, 1,0,1,0,0});
        vecs.push_back('{0,0,0,2,1, 3,0,0,0,0});
        vecs.push_back('{0,0,0,2,1, 3,1,0,0,0});
        vecs.push_back('{0,0,0,7,1, 3,0,0,0,0});
        vecs.push_back('{0,0,0,7,0, 0,0,0,0,0});
        vecs.push_back('{0,0,0,7,0, 1,0,1,0,0});
        vecs.push_back('{1,0,0,7,0, 1,0,1,0,0});
        vecs.push_back('{1,0,0,7,0, 1,0,1,0,0});
        vecs.push_back('{1,0,0,7,0, 1,0,1,0,0});
        vecs.push_back('{1,0,0,7,0, 1,0,1,0,0});
        vecs.push_back('{0,0,0,7,0, 4,0,0,1,0});
        vecs.push_back('{1,0,0,7,0, 4,0,0,1,0});
        vecs.push_back('{0,1,7,7,0, 0,0,0,0,1});

        doReset(0);
        #1;
        checkOutput("reset", S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].tk, vecs[i].ld, vecs[i].sp, vecs[i].temp, vecs[i].drip);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].inc,
                        vecs[i].dec, vecs[i].flt, vecs[i].at);
        end

        runLoop("loop_up_0_to_3", 0, 3, 3, 0);
        runLoop("loop_down_5_to_1", 5, 1, 0, 4);

        // Asynchronous reset in the middle of a request
        doReset(0);
        applyStimulus(1'b0, 1'b1, 5, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        cmp("async_pre increase", int'(increase), 1);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async increase", int'(increase), 0);
        cmp("async state_o", int'(state_o), S_IDLE);
        cmp("async busy", int'(busy), 0);
        modelReset();
        @(negedge clk_2);
        reset_n = 1'b1;
        #1;
        cmp("async_rel fault", int'(fault), 0);
        cmp("async_rel at_target", int'(at_target), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("async_rel_sp", S_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized closed loop against the behavioural model
        doReset(0);
        t = 0; ptk = 0; dr = 0;
        for (int c = 0; c < 3000; c++) begin
            tk = !ptk && ($urandom_range(0, 2) == 0);
            ld = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) dr = !dr;
            ib = m_inc; db = m_dec;
            applyStimulus(tk, ld, int'($urandom_range(0, 7)), t, dr);
            checkModel($sformatf("rand%0d", c));
            if (tk && $urandom_range(0, 5) != 0) begin
                if (ib && t < 7) t++;
                if (db && t > 0) t--;
            end
            ptk = tk;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_setpoint_controller.md
Name: ac_setpoint_controller

Overview:
Closed-loop sequencer for the air-conditioner temperature datapath. It stores a desired temperature and drives the increase/decrease request lines of the AC block one step at a time until the reported temperature matches the setpoint. It pauses while the AC is dripping and flags a fault if the AC stops responding. It sits between the switch/LCD front end and the AC core, replacing direct switch control of increase/decrease.

Parameters:
TEMP_NBITS, 3, width of temperature and setpoint codes (0 = 20 degrees, 7 = 27 degrees)
SP_RESET, 3'd0, setpoint value after reset
TIMEOUT_TICKS, 4, ticks allowed for the AC to respond to one step request
DRIP_ASSIST, 1'b1, 1 = drive temperature to max while dripping to speed up drip clearing

Ports:
clk_2  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tick  in  1  one-cycle step-rate enable, at the AC clock rate
load  in  1  one-cycle strobe: capture setpoint
setpoint  in  TEMP_NBITS  desired temperature code
temperature  in  TEMP_NBITS  current temperature from the AC
dripping  in  1  AC drip flag
increase  out  1  step-up request to the AC
decrease  out  1  step-down request to the AC
at_target  out  1  temperature == stored setpoint, and state is IDLE
busy  out  1  state is REQ or SETTLE
fault  out  1  AC failed to respond within TIMEOUT_TICKS
state_o  out  3  current state code, for the LCD

Behaviour:
- Clock and reset: one clock, clk_2. Reset is asynchronous, active-low reset_n.
- Reset values: state=IDLE, sp=SP_RESET, timeout counter=0, increase=0, decrease=0, fault=0, busy=0. at_target is combinational from registered state and sp.
- All state, sp and request outputs are registered.
- increase and decrease are never 1 in the same cycle. The bench asserts this.
- States: IDLE, REQ, SETTLE, HOLD, FAULT.
- IDLE:
  - dripping=1 -> HOLD.
  - Else temperature != sp -> REQ. On the next edge, increase=1 if temperature<sp, else decrease=1 (one-cycle latency).
  - Otherwise stay; outputs 0.
- REQ:
  - Direction is latched on entry, in t0 = temperature at entry.
  - The request line is held high as a level.
  - Every tick increments the timeout counter.
  - Temperature moves one step in the latched direction -> SETTLE, both requests 0, counter cleared.
  - Counter reaches TIMEOUT_TICKS with no movement -> FAULT.
  - dripping rises -> HOLD; requests drop on the same edge.
- SETTLE:
  - Requests stay 0 until the next tick, so the AC sees a low phase between steps.
  - Then -> IDLE, which re-evaluates the error.
- HOLD:
  - DRIP_ASSIST=1: increase=1 while temperature<7, else 0.
  - DRIP_ASSIST=0: both requests 0.
  - dripping falls -> IDLE, requests 0.
- FAULT:
  - fault=1, requests 0.
  - Left only by load (-> IDLE, fault cleared, sp updated) or by reset.
- load:
  - In any state, sp <= setpoint.
  - In REQ or SETTLE: abort to IDLE, requests 0 next cycle, counter cleared.
  - In HOLD: stay in HOLD.
  - load takes priority over a simultaneous temperature change or timeout in the same cycle.
- Arithmetic:
  - Unsigned compares, TEMP_NBITS wide.
  - Timeout counter is $clog2(TIMEOUT_TICKS+1) bits and saturates.
  - The controller never requests increase at temperature 7 or decrease at 0. It is unreachable when sp is in range.
- Reset mid-REQ: requests drop immediately (asynchronously).
- state_o encoding: IDLE=0, REQ=1, SETTLE=2, HOLD=3, FAULT=4.

Decomposition:
- Package ac_ctrl_pkg holds:
  - state enum ac_ctrl_state_t, logic [2:0];
  - TEMP_MAX=7 and TEMP_MIN=0;
  - direction typedef {DIR_UP, DIR_DOWN}.
- Sub-module ac_timeout_counter: tick-enabled, clearable, saturating counter with a done flag.
- Top-level integration (not part of this block) drives tick from the 1 Hz clock edge and feeds temperature and dripping back from the AC.

Test Plan:
- Reset, load setpoint=3 with temperature=0, model AC steps +1 per tick -> increase pulses three times with a one-tick low SETTLE gap between each; at_target=1 when temperature=3; decrease never asserted.
- temperature=5, load setpoint=1 -> decrease pulses four times; final state_o=0, at_target=1.
- setpoint=4, model AC frozen at temperature=2 -> increase held high for 4 ticks, then fault=1, state_o=4, requests 0; load setpoint=2 -> fault=0, at_target=1.
- In REQ toward setpoint 6, assert dripping -> same edge: state HOLD; increase=1 until temperature=7 (DRIP_ASSIST=1); dripping falls -> IDLE, then decrease steps to 6.
- In REQ (increasing), load setpoint=temperature in the same cycle the temperature changes -> next state IDLE (load wins), requests 0, no spurious SETTLE.
- Drop reset_n mid-REQ between clock edges -> increase=0 immediately; after release state_o=0, sp=SP_RESET, fault=0.
